// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer datapath.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/timer_loader_if.sv
// Keypad-encoder side signals and the displayed time / status of the timer.
interface timer_loader_if;
  import microwave_pkg::*;

  bcd_t D;
  logic loadn;
  logic pgt_1Hz;
  logic Startn;
  logic Stopn;
  bcd_t Mins;
  bcd_t SecTens;
  bcd_t SecOnes;
  logic Enablen;
  logic MagOn;
  logic Zero;

  modport master (
    output D, loadn, pgt_1Hz, Startn, Stopn,
    input  Mins, SecTens, SecOnes, Enablen, MagOn, Zero
  );

  modport slave (
    input  D, loadn, pgt_1Hz, Startn, Stopn,
    output Mins, SecTens, SecOnes, Enablen, MagOn, Zero
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps to a caller-chosen value and borrows at 0.
module bcd_down_digit
  import microwave_pkg::*;
(
  input  bcd_t digit,
  input  logic dec_en,
  input  bcd_t wrap_val,
  output bcd_t digit_nxt,
  output logic borrow
);

  always_comb begin
    digit_nxt = digit;
    borrow    = 1'b0;
    if (dec_en) begin
      if (digit == 4'd0) begin
        digit_nxt = wrap_val;
        borrow    = 1'b1;
      end else begin
        digit_nxt = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/timer_loader.sv
// Microwave cook timer: keypad shift-load of M:SS, 1 Hz BCD countdown, start/pause control.
module timer_loader
  import microwave_pkg::*;
(
  input  logic           Clk,
  input  logic           Clearn,
  timer_loader_if.slave  bus
);

  state_t state, state_nxt;
  logic   loadn_q, tick_q;
  bcd_t   mins, sec_tens, sec_ones;
  bcd_t   mins_dec, tens_dec, ones_dec;
  logic   ones_borrow, tens_borrow, mins_borrow;
  logic   key_ev, tick_ev, key_ok, dec_en, zero, dec_zero;
  logic   enablen, mag_on;

  // Edge detectors on the encoder's strobe and timebase
  assign key_ev  = !bus.loadn && loadn_q;
  assign tick_ev = bus.pgt_1Hz && !tick_q;

  assign key_ok = key_ev && (bus.D <= BCD_MAX) && ((state == IDLE) || (state == DONE));
  assign dec_en = (state == COUNT) && tick_ev && bus.Stopn;
  assign zero   = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);

  bcd_down_digit u_ones (
    .digit(sec_ones), .dec_en(dec_en), .wrap_val(BCD_MAX),
    .digit_nxt(ones_dec), .borrow(ones_borrow)
  );

  bcd_down_digit u_tens (
    .digit(sec_tens), .dec_en(ones_borrow), .wrap_val(SEC_TENS_MAX),
    .digit_nxt(tens_dec), .borrow(tens_borrow)
  );

  bcd_down_digit u_mins (
    .digit(mins), .dec_en(tens_borrow), .wrap_val(BCD_MAX),
    .digit_nxt(mins_dec), .borrow(mins_borrow)
  );

  assign dec_zero = (mins_dec == 4'd0) && (tens_dec == 4'd0) && (ones_dec == 4'd0);

  always_comb begin
    state_nxt = state;
    enablen   = 1'b0;
    mag_on    = 1'b0;
    case (state)
      IDLE: begin
        // Any key press this cycle blocks a simultaneous start
        if (!key_ev && !bus.Startn && !zero) state_nxt = COUNT;
      end
      COUNT: begin
        enablen = 1'b1;
        mag_on  = 1'b1;
        if (!bus.Stopn)             state_nxt = PAUSE;
        else if (dec_en && dec_zero) state_nxt = DONE;
      end
      PAUSE: begin
        enablen = 1'b1;
        if (!bus.Startn && bus.Stopn) state_nxt = COUNT;
      end
      DONE: begin
        if (key_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clearn) begin
      state    <= IDLE;
      loadn_q  <= 1'b1;
      tick_q   <= 1'b1;
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      state   <= state_nxt;
      loadn_q <= bus.loadn;
      tick_q  <= bus.pgt_1Hz;
      if (key_ok) begin
        // A fresh entry after DONE starts from 0:0D rather than shifting stale digits
        mins     <= (state == DONE) ? 4'd0 : sec_tens;
        sec_tens <= (state == DONE) ? 4'd0 : sec_ones;
        sec_ones <= bus.D;
      end else if (dec_en) begin
        mins     <= mins_dec;
        sec_tens <= tens_dec;
        sec_ones <= ones_dec;
      end
    end
  end

  assign bus.Mins    = mins;
  assign bus.SecTens = sec_tens;
  assign bus.SecOnes = sec_ones;
  assign bus.Zero    = zero;
  assign bus.Enablen = enablen;
  assign bus.MagOn   = mag_on;

endmodule

// File: tb/tb_timer_loader.sv
// Scoreboard bench for timer_loader: expected displays queued per stimulus step, popped at sample.
module tb_timer_loader;
  import microwave_pkg::*;

  logic Clk = 1'b0;
  logic Clearn;
  int   n_checks = 0;
  int   n_fail   = 0;

  timer_loader_if ifc ();

  timer_loader u_dut (
    .Clk   (Clk),
    .Clearn(Clearn),
    .bus   (ifc)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string tag;
    int    mins, tens, ones, en, mag, zero;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int m, input int t, input int o,
                          input int en, input int mag, input int zero);
    exp_t e;
    e.tag = tag; e.mins = m; e.tens = t; e.ones = o;
    e.en = en; e.mag = mag; e.zero = zero;
    sb_q.push_back(e);
  endtask

  // Pops one expectation and compares against the outputs, sampled 1 time unit after the edge
  task automatic sample();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".Mins"},    int'(ifc.Mins),    e.mins);
    check({e.tag, ".SecTens"}, int'(ifc.SecTens), e.tens);
    check({e.tag, ".SecOnes"}, int'(ifc.SecOnes), e.ones);
    check({e.tag, ".Enablen"}, int'(ifc.Enablen), e.en);
    check({e.tag, ".MagOn"},   int'(ifc.MagOn),   e.mag);
    check({e.tag, ".Zero"},    int'(ifc.Zero),    e.zero);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clearn = 1'b0;
    cyc();
    Clearn = 1'b1;
  endtask

  task automatic press(input int d);
    ifc.D = 4'(d);
    ifc.loadn = 1'b0;
    cyc();
    ifc.loadn = 1'b1;
    cyc();
  endtask

  task automatic tick();
    ifc.pgt_1Hz = 1'b1;
    cyc();
    ifc.pgt_1Hz = 1'b0;
    cyc();
  endtask

  task automatic start();
    ifc.Startn = 1'b0;
    cyc();
    ifc.Startn = 1'b1;
    cyc();
  endtask

  initial begin
    Clearn      = 1'b0;
    ifc.D       = 4'd0;
    ifc.loadn   = 1'b1;
    ifc.pgt_1Hz = 1'b0;
    ifc.Startn  = 1'b1;
    ifc.Stopn   = 1'b1;
    cyc();
    cyc();
    Clearn = 1'b1;
    push_exp("reset", 0, 0, 0, 0, 0, 1); sample();

    // Keypad shift load
    press(1); press(3); press(0);
    push_exp("load130", 1, 3, 0, 0, 0, 0); sample();

    // 1:00 -> 0:59 across both borrows; key ignored while counting
    do_reset();
    press(1); press(0); press(0);
    start();
    push_exp("started", 1, 0, 0, 1, 1, 0); sample();
    tick();
    push_exp("tick059", 0, 5, 9, 1, 1, 0); sample();
    press(7);
    push_exp("key_in_count", 0, 5, 9, 1, 1, 0); sample();

    // Count to zero, DONE, then reload
    do_reset();
    press(0); press(0); press(2);
    start();
    tick();
    push_exp("tick001", 0, 0, 1, 1, 1, 0); sample();
    tick();
    push_exp("done", 0, 0, 0, 0, 0, 1); sample();
    tick();
    push_exp("tick_in_done", 0, 0, 0, 0, 0, 1); sample();
    press(4);
    push_exp("reload004", 0, 0, 4, 0, 0, 0); sample();
    press(5);
    push_exp("shift045", 0, 4, 5, 0, 0, 0); sample();

    // Stop wins over a simultaneous tick; ticks ignored in PAUSE; resume
    do_reset();
    press(0); press(1); press(0);
    start();
    ifc.pgt_1Hz = 1'b1;
    ifc.Stopn   = 1'b0;
    cyc();
    ifc.pgt_1Hz = 1'b0;
    ifc.Stopn   = 1'b1;
    cyc();
    push_exp("stop_tick", 0, 1, 0, 1, 0, 0); sample();
    tick();
    push_exp("tick_in_pause", 0, 1, 0, 1, 0, 0); sample();
    ifc.Startn = 1'b0;
    ifc.Stopn  = 1'b0;
    cyc();
    ifc.Startn = 1'b1;
    ifc.Stopn  = 1'b1;
    cyc();
    push_exp("start_and_stop", 0, 1, 0, 1, 0, 0); sample();
    start();
    push_exp("resume", 0, 1, 0, 1, 1, 0); sample();
    tick();
    push_exp("tick009", 0, 0, 9, 1, 1, 0); sample();

    // Load beats start in the same cycle; start with 000 ignored
    do_reset();
    press(0); press(0); press(5);
    ifc.D      = 4'd5;
    ifc.loadn  = 1'b0;
    ifc.Startn = 1'b0;
    cyc();
    ifc.loadn  = 1'b1;
    ifc.Startn = 1'b1;
    cyc();
    push_exp("load_vs_start", 0, 5, 5, 0, 0, 0); sample();
    do_reset();
    start();
    push_exp("start_zero", 0, 0, 0, 0, 0, 1); sample();

    // SecTens above 5 counts down normally
    press(0); press(9); press(0);
    start();
    tick();
    push_exp("tens9", 0, 8, 9, 1, 1, 0); sample();

    // Reset mid-count, with a tick in the reset cycle discarded
    do_reset();
    press(2); press(3); press(2);
    start();
    tick();
    push_exp("tick231", 2, 3, 1, 1, 1, 0); sample();
    Clearn      = 1'b0;
    ifc.pgt_1Hz = 1'b1;
    cyc();
    Clearn      = 1'b1;
    ifc.pgt_1Hz = 1'b0;
    push_exp("reset_mid", 0, 0, 0, 0, 0, 1); sample();
    press(12);
    push_exp("key_d12", 0, 0, 0, 0, 0, 1); sample();
    press(8);
    push_exp("key_after_reset", 0, 0, 8, 0, 0, 0); sample();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1);
  end

endmodule
